// File: rtl/zap_pipe_pkg.sv
// Shared types for the flushable/stallable pipeline stage buffers.
//   action_t : resolved per-cycle action of a stage (normal, stall, clear).
//   LVL_*    : priority-level indices used by the decode-stage instances.
//              Level 0 is the highest priority.
package zap_pipe_pkg;

  typedef enum logic [1:0] {
    ACT_NORMAL = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_CLEAR  = 2'd2
  } action_t;

  // Decode ordering: level0 clear = writeback and level0 stall = data stall,
  // level1 clear = ALU, level2 stall = shifter|issue|decode, level3 clear = decode.
  localparam int unsigned LVL_WB    = 0;
  localparam int unsigned LVL_ALU   = 1;
  localparam int unsigned LVL_SHIFT = 2;
  localparam int unsigned LVL_DEC   = 3;

endpackage

// File: rtl/zap_prio_resolve.sv
// Combinational clear/stall priority resolver.
// Scans the levels from 0 (highest) upward. The first level with any request
// decides the action. Within one level a clear beats a stall.
//   i_clear  [NLVL] : clear requests, bit 0 highest
//   i_stall  [NLVL] : stall requests, bit 0 highest
//   o_action        : ACT_CLEAR / ACT_STALL / ACT_NORMAL
module zap_prio_resolve
  import zap_pipe_pkg::*;
#(
  parameter int unsigned NLVL = 5
) (
  input  logic [NLVL-1:0] i_clear,
  input  logic [NLVL-1:0] i_stall,
  output action_t         o_action
);

  action_t w_action;

  // Walk from the lowest priority up so the highest asserted level is applied last.
  always_comb begin
    w_action = ACT_NORMAL;
    for (int k = int'(NLVL) - 1; k >= 0; k--) begin
      if (i_clear[k]) begin
        w_action = ACT_CLEAR;
      end else if (i_stall[k]) begin
        w_action = ACT_STALL;
      end
    end
  end

  assign o_action = w_action;

endmodule

// File: rtl/zap_prio_pipe_fifo.sv
// Configurable-depth stage buffer between two pipeline stages, governed by a
// level-ordered clear/stall priority network. It accepts pushes while the
// downstream side is stalled, as long as there is room.
// Optional feature: define ZAP_PIPE_HWM_EN to add o_hwm, the occupancy high-water mark.
//   i_clk, i_reset   : clock and synchronous active-high reset
//   i_clear, i_stall : per-level clear/stall requests (bit 0 highest)
//   i_valid, i_payload, i_sb : upstream entry
//   o_ready          : upstream may push this cycle (combinational on clear/stall)
//   o_valid, o_payload, o_sb : head entry (o_sb is 0 when empty)
//   o_count          : occupancy
//   o_hwm            : (ZAP_PIPE_HWM_EN only) max occupancy since reset
module zap_prio_pipe_fifo
  import zap_pipe_pkg::*;
#(
  parameter int unsigned DW    = 109,
  parameter int unsigned SBW   = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned NLVL  = 5
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NLVL-1:0]              i_clear,
  input  logic [NLVL-1:0]              i_stall,
  input  logic                         i_valid,
  input  logic [DW-1:0]                i_payload,
  input  logic [SBW-1:0]               i_sb,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic [DW-1:0]                o_payload,
  output logic [SBW-1:0]               o_sb,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
`ifdef ZAP_PIPE_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   o_hwm
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Storage is sized to the full pointer range so every pointer value indexes a real
  // entry. Entries at DEPTH and above are never written.
  localparam int unsigned NMEM = 2 ** PW;

  action_t        w_action;
  logic           w_full;
  logic           w_empty;
  logic           w_ready;
  logic           w_push;
  logic           w_pop;

  logic [DW-1:0]  r_mem   [NMEM];
  logic [SBW-1:0] r_sbmem [NMEM];
  logic [PW-1:0]  r_rd;
  logic [PW-1:0]  r_wr;
  logic [CW-1:0]  r_count;

  zap_prio_resolve #(
    .NLVL (NLVL)
  ) u_resolve (
    .i_clear  (i_clear),
    .i_stall  (i_stall),
    .o_action (w_action)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // When the queue is full, a push is allowed only if a pop frees a slot in the same cycle.
  assign w_ready = (w_action != ACT_CLEAR) &&
                   (!w_full || ((w_action == ACT_NORMAL) && !w_empty));
  assign w_push  = i_valid && w_ready;
  assign w_pop   = (w_action == ACT_NORMAL) && !w_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      for (int i = 0; i < int'(NMEM); i++) begin
        r_mem[i]   <= '0;
        r_sbmem[i] <= '0;
      end
    end else if (w_action == ACT_CLEAR) begin
      // Payload storage is deliberately kept. Only the occupancy and the sideband are dropped.
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      for (int i = 0; i < int'(NMEM); i++) begin
        r_sbmem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr]   <= i_payload;
        r_sbmem[r_wr] <= i_sb;
        r_wr          <= ptr_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= ptr_inc(r_rd);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef ZAP_PIPE_HWM_EN
  logic [CW-1:0] r_hwm;

  // Tracks the registered occupancy, so it lags a count change by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hwm <= '0;
    end else if (r_count > r_hwm) begin
      r_hwm <= r_count;
    end
  end

  assign o_hwm = r_hwm;
`endif

  assign o_ready   = w_ready;
  assign o_valid   = !w_empty;
  assign o_payload = r_mem[r_rd];
  assign o_sb      = w_empty ? '0 : r_sbmem[r_rd];
  assign o_count   = r_count;

endmodule

// File: tb/tb_zap_prio_pipe_fifo.sv
// Self-checking bench: a DEPTH=2 and a DEPTH=1 instance share the same stimulus.
// The DEPTH=2 instance is checked against a queue model. The DEPTH=1 instance is
// checked against a single-register model.
module tb_zap_prio_pipe_fifo;

  localparam int unsigned DW   = 109;
  localparam int unsigned SBW  = 4;
  localparam int unsigned NLVL = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NLVL-1:0] clr;
  logic [NLVL-1:0] stl;
  logic            vld;
  logic [DW-1:0]   pl;
  logic [SBW-1:0]  sb;

  logic            rdy2, val2;
  logic [DW-1:0]   pl2;
  logic [SBW-1:0]  sb2;
  logic [1:0]      cnt2;
  logic            rdy1, val1;
  logic [DW-1:0]   pl1;
  logic [SBW-1:0]  sb1;
  logic [0:0]      cnt1;
`ifdef ZAP_PIPE_HWM_EN
  logic [1:0]      hwm2;
  logic [0:0]      hwm1;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Queue model for the DEPTH=2 instance; each element is {sb, payload}.
  logic [DW+SBW-1:0] q[$];
  bit                fresh;
  int                m_hwm2;
  // Single-register model for the DEPTH=1 instance.
  logic              m1_v;
  logic [DW-1:0]     m1_p;
  logic [SBW-1:0]    m1_sb;
  int                m_hwm1;

  always #5 clk = ~clk;

  zap_prio_pipe_fifo #(
    .DW(DW), .SBW(SBW), .DEPTH(2), .NLVL(NLVL)
  ) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_stall(stl), .i_valid(vld),
    .i_payload(pl), .i_sb(sb), .o_ready(rdy2), .o_valid(val2), .o_payload(pl2),
    .o_sb(sb2), .o_count(cnt2)
`ifdef ZAP_PIPE_HWM_EN
    , .o_hwm(hwm2)
`endif
  );

  zap_prio_pipe_fifo #(
    .DW(DW), .SBW(SBW), .DEPTH(1), .NLVL(NLVL)
  ) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_stall(stl), .i_valid(vld),
    .i_payload(pl), .i_sb(sb), .o_ready(rdy1), .o_valid(val1), .o_payload(pl1),
    .o_sb(sb1), .o_count(cnt1)
`ifdef ZAP_PIPE_HWM_EN
    , .o_hwm(hwm1)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 = normal, 1 = stall, 2 = clear; first asserted level wins, clear before stall.
  function automatic int act(input logic [NLVL-1:0] c, input logic [NLVL-1:0] s);
    for (int k = 0; k < int'(NLVL); k++) begin
      if (c[k]) return 2;
      if (s[k]) return 1;
    end
    return 0;
  endfunction

  // Applies one cycle of stimulus, checks o_ready before the edge and the state after it.
  task automatic step(input logic r, input logic [NLVL-1:0] c, input logic [NLVL-1:0] s,
                      input logic v, input logic [DW-1:0] p, input logic [SBW-1:0] b);
    int                a;
    logic              e_rdy2, e_rdy1;
    logic [DW+SBW-1:0] head;
    rst = r; clr = c; stl = s; vld = v; pl = p; sb = b;
    #2;
    a      = act(c, s);
    e_rdy2 = (a != 2) && (q.size() < 2 || (a == 0 && q.size() != 0));
    e_rdy1 = (a != 2) && (!m1_v || a == 0);
    if (!r) begin
      chk("rdy2", rdy2, e_rdy2);
      chk("rdy1", rdy1, e_rdy1);
    end
    @(posedge clk);
    if (r) begin
      q.delete(); fresh = 1'b1; m_hwm2 = 0;
      m1_v = 1'b0; m1_p = '0; m1_sb = '0; m_hwm1 = 0;
    end else begin
      if (q.size() > m_hwm2) m_hwm2 = q.size();
      if (int'(m1_v) > m_hwm1) m_hwm1 = int'(m1_v);
      if (a == 2) begin
        q.delete();
        m1_v = 1'b0; m1_sb = '0;
      end else begin
        if (a == 0 && q.size() != 0) void'(q.pop_front());
        if (v && e_rdy2) begin
          q.push_back({b, p});
          fresh = 1'b0;
        end
        if (v && (a == 0 || !m1_v)) begin
          m1_v = 1'b1; m1_p = p; m1_sb = b;
        end else if (a == 0) begin
          m1_v = 1'b0;
        end
      end
    end
    #1;
    chk("val2", val2, q.size() != 0);
    chk("cnt2", cnt2, q.size());
    if (q.size() != 0) begin
      head = q[0];
      chk("pl2", pl2, head[DW-1:0]);
      chk("sb2", sb2, head[DW+SBW-1:DW]);
    end else begin
      chk("sb2_empty", sb2, 0);
      if (fresh) chk("pl2_rst", pl2, 0);
    end
    chk("val1", val1, m1_v);
    chk("cnt1", cnt1, m1_v);
    chk("pl1", pl1, m1_p);
    chk("sb1", sb1, m1_v ? m1_sb : '0);
`ifdef ZAP_PIPE_HWM_EN
    chk("hwm2", hwm2, m_hwm2);
    chk("hwm1", hwm1, m_hwm1);
`endif
  endtask

  initial begin
    logic [NLVL-1:0] rc, rs;
    logic [DW-1:0]   rp;
    m1_v = 1'b0; m1_p = '0; m1_sb = '0; fresh = 1'b1; m_hwm2 = 0; m_hwm1 = 0;
    rst = 1'b1; clr = '0; stl = '0; vld = 1'b0; pl = '0; sb = '0;
    @(posedge clk);
    #1;

    // Reset held with a valid push present.
    step(1'b1, '0, '0, 1'b1, DW'('hA5), 4'b0100);
    step(1'b1, '0, '0, 1'b1, DW'('hA5), 4'b0100);
    chk("rst_valid", val2, 1'b0);
    chk("rst_ready", rdy2, 1'b1);
    step(1'b0, '0, '0, 1'b1, DW'('hA5), 4'b0100);
    chk("first_pl", pl2, 'hA5);
    chk("first_sb", sb2, 4'b0100);
    step(1'b0, '0, '0, 1'b0, '0, '0);

    // Stall fill at level 2; the third push is dropped.
    step(1'b0, '0, 5'b00100, 1'b1, DW'('h11), 4'h1);
    step(1'b0, '0, 5'b00100, 1'b1, DW'('h22), 4'h2);
    step(1'b0, '0, 5'b00100, 1'b1, DW'('h33), 4'h3);
    chk("stall_full_head", pl2, 'h11);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b0, '0, '0);

    // Stall at a higher priority level beats a clear at a lower one; then a bare clear.
    step(1'b0, '0, 5'b00100, 1'b1, DW'('h44), 4'h4);
    step(1'b0, '0, 5'b00100, 1'b1, DW'('h55), 4'h5);
    step(1'b0, 5'b00010, 5'b00001, 1'b1, DW'('h66), 4'h6);
    chk("prio_hold", cnt2, 2);
    step(1'b0, 5'b01000, '0, 1'b1, DW'('h77), 4'h7);
    chk("clear_cnt", cnt2, 0);
    // A clear and a stall on the same level: the clear wins.
    step(1'b0, 5'b00100, 5'b00100, 1'b0, '0, '0);

    // Streaming at full occupancy: fill under stall, then push and pop every cycle.
    step(1'b0, '0, 5'b00100, 1'b1, DW'(1), 4'h1);
    step(1'b0, '0, 5'b00100, 1'b1, DW'(2), 4'h2);
    for (int i = 3; i <= 10; i++) begin
      step(1'b0, '0, '0, 1'b1, DW'(i), SBW'(i));
      chk("stream_cnt", cnt2, 2);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset in the middle of operation.
    step(1'b0, '0, 5'b00001, 1'b1, DW'('h99), 4'h9);
    step(1'b1, '0, '0, 1'b0, '0, '0);

    // High-water mark: fill to 2 under stall, clear, refill to 1.
    step(1'b0, '0, 5'b00100, 1'b1, DW'('h21), 4'h1);
    step(1'b0, '0, 5'b00100, 1'b1, DW'('h22), 4'h2);
    step(1'b0, 5'b00001, '0, 1'b0, '0, '0);
    step(1'b0, '0, 5'b00100, 1'b1, DW'('h23), 4'h3);
    step(1'b0, '0, 5'b00100, 1'b0, '0, '0);

    // Randomized traffic.
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < int'(NLVL); k++) begin
        rc[k] = ($urandom_range(0, 11) == 0);
        rs[k] = ($urandom_range(0, 4) == 0);
      end
      rp = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 99) == 0, rc, rs, $urandom_range(0, 3) != 0, rp, SBW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
